// File: rtl/boot_pkg.sv
// Shared types and constants for the program-load sequencer.
package boot_pkg;

    // Sequencer states, from power-up through program load, readback and run.
    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        VERIFY,
        RUN,
        ERROR
    } boot_state_e;

    // Checksum accumulator width; also the default instruction word width.
    localparam int SUM_WIDTH = 32;

endpackage

// File: rtl/imem_port_mux.sv
// Instruction-memory port selection: the loader owns the port until the core runs.
module imem_port_mux
    import boot_pkg::*;
#(
    parameter int DataWidth = SUM_WIDTH,
    parameter int AddrWidth = 10
) (
    input  logic                 run_sel,
    input  logic [AddrWidth-1:0] loader_address,
    input  logic [DataWidth-1:0] loader_data,
    input  logic                 loader_write_en,
    input  logic                 loader_read_en,
    input  logic [AddrWidth-1:0] core_address,
    input  logic                 core_read_en,
    output logic [AddrWidth-1:0] imem_address,
    output logic [DataWidth-1:0] imem_dataIn,
    output logic                 imem_write_en,
    output logic                 imem_read_en
);

    // Purely combinational so the core's fetch path sees no extra latency.
    always_comb begin
        imem_address  = loader_address;
        imem_dataIn   = loader_data;
        imem_write_en = loader_write_en;
        imem_read_en  = loader_read_en;
        if (run_sel) begin
            imem_address  = core_address;
            imem_dataIn   = '0;
            imem_write_en = 1'b0;
            imem_read_en  = core_read_en;
        end
    end

endmodule

// File: rtl/prog_load_ctrl.sv
// Boot sequencer: streams a program image into instruction memory, reads it
// back to confirm the checksum, then releases the core onto the memory port.
module prog_load_ctrl
    import boot_pkg::*;
#(
    parameter int DataWidth = SUM_WIDTH,
    parameter int AddrWidth = 10
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 load_start,
    input  logic                 prog_valid,
    output logic                 prog_ready,
    input  logic [DataWidth-1:0] program_in,
    input  logic [AddrWidth-1:0] address_in,
    input  logic                 prog_last,
    output logic                 core_reset,
    input  logic [AddrWidth-1:0] core_imem_address,
    input  logic                 core_imem_read_en,
    output logic [AddrWidth-1:0] imem_address,
    output logic [DataWidth-1:0] imem_dataIn,
    output logic                 imem_write_en,
    output logic                 imem_read_en,
    input  logic [DataWidth-1:0] imem_dataOut,
    output logic                 load_done,
    output logic                 load_error,
    output logic [AddrWidth:0]   words_loaded
);

    // A full memory holds exactly 2**AddrWidth words; one more is an overflow.
    localparam logic [AddrWidth:0] WORDS_MAX = {1'b1, {AddrWidth{1'b0}}};

    boot_state_e            state;
    boot_state_e            next_state;
    logic [AddrWidth:0]     rd_ptr;
    logic [DataWidth-1:0]   load_sum;
    logic [DataWidth-1:0]   verify_sum;
    logic [DataWidth-1:0]   verify_total;
    logic                   accept_ok;
    logic [AddrWidth-1:0]   loader_address;
    logic [DataWidth-1:0]   loader_data;
    logic                   loader_write_en;
    logic                   loader_read_en;

    // Next-state and loader-side memory controls; load_start overrides everything
    // and a word offered alongside it is dropped.
    always_comb begin
        next_state      = state;
        prog_ready      = 1'b0;
        accept_ok       = 1'b0;
        loader_address  = '0;
        loader_data     = '0;
        loader_write_en = 1'b0;
        loader_read_en  = 1'b0;
        verify_total    = verify_sum + ((rd_ptr != '0) ? imem_dataOut : '0);
        case (state)
            LOAD: begin
                prog_ready = 1'b1;
                if (prog_valid && !load_start) begin
                    if (words_loaded == WORDS_MAX ||
                        {1'b0, address_in} != words_loaded) begin
                        next_state = ERROR;
                    end else begin
                        accept_ok       = 1'b1;
                        loader_write_en = 1'b1;
                        loader_address  = address_in;
                        loader_data     = program_in;
                        if (prog_last) begin
                            next_state = VERIFY;
                        end
                    end
                end
            end
            VERIFY: begin
                loader_address = rd_ptr[AddrWidth-1:0];
                loader_read_en = (rd_ptr < words_loaded);
                if (rd_ptr == words_loaded) begin
                    next_state = (verify_total == load_sum) ? RUN : ERROR;
                end
            end
            default: begin
            end
        endcase
        if (load_start) begin
            next_state = LOAD;
        end
    end

    // State, word counter, read pointer and both checksums.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            words_loaded <= '0;
            rd_ptr       <= '0;
            load_sum     <= '0;
            verify_sum   <= '0;
        end else begin
            state <= next_state;
            if (load_start) begin
                words_loaded <= '0;
                rd_ptr       <= '0;
                load_sum     <= '0;
                verify_sum   <= '0;
            end else begin
                if (accept_ok) begin
                    words_loaded <= words_loaded + 1'b1;
                    load_sum     <= load_sum + program_in;
                end
                if (state == VERIFY) begin
                    rd_ptr     <= rd_ptr + 1'b1;
                    verify_sum <= verify_total;
                end
            end
        end
    end

    assign core_reset = (state != RUN);
    assign load_done  = (state == RUN);
    assign load_error = (state == ERROR);

    imem_port_mux #(
        .DataWidth (DataWidth),
        .AddrWidth (AddrWidth)
    ) u_port_mux (
        .run_sel         (state == RUN),
        .loader_address  (loader_address),
        .loader_data     (loader_data),
        .loader_write_en (loader_write_en),
        .loader_read_en  (loader_read_en),
        .core_address    (core_imem_address),
        .core_read_en    (core_imem_read_en),
        .imem_address    (imem_address),
        .imem_dataIn     (imem_dataIn),
        .imem_write_en   (imem_write_en),
        .imem_read_en    (imem_read_en)
    );

endmodule

// File: tb/tb_prog_load_ctrl.sv
// Scoreboard bench for prog_load_ctrl with a small synchronous memory model.
module tb_prog_load_ctrl;

    localparam int DW = 32;
    localparam int AW = 3;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          load_start = 1'b0;
    logic          prog_valid = 1'b0;
    logic          prog_ready;
    logic [DW-1:0] program_in = '0;
    logic [AW-1:0] address_in = '0;
    logic          prog_last = 1'b0;
    logic          core_reset;
    logic [AW-1:0] core_imem_address = '0;
    logic          core_imem_read_en = 1'b0;
    logic [AW-1:0] imem_address;
    logic [DW-1:0] imem_dataIn;
    logic          imem_write_en;
    logic          imem_read_en;
    logic [DW-1:0] imem_dataOut = '0;
    logic          load_done;
    logic          load_error;
    logic [AW:0]   words_loaded;

    logic [DW-1:0] mem [0:(2**AW)-1];
    logic          corrupt = 1'b0;
    wr_t           exp_q [$];
    int            checks = 0;
    int            errors = 0;
    int            cycles;

    prog_load_ctrl #(.DataWidth(DW), .AddrWidth(AW)) dut (
        .clock             (clock),
        .reset             (reset),
        .load_start        (load_start),
        .prog_valid        (prog_valid),
        .prog_ready        (prog_ready),
        .program_in        (program_in),
        .address_in        (address_in),
        .prog_last         (prog_last),
        .core_reset        (core_reset),
        .core_imem_address (core_imem_address),
        .core_imem_read_en (core_imem_read_en),
        .imem_address      (imem_address),
        .imem_dataIn       (imem_dataIn),
        .imem_write_en     (imem_write_en),
        .imem_read_en      (imem_read_en),
        .imem_dataOut      (imem_dataOut),
        .load_done         (load_done),
        .load_error        (load_error),
        .words_loaded      (words_loaded)
    );

    // Free-running 10-unit clock.
    always #5 clock = ~clock;

    // Instruction memory model with 1-cycle read; can corrupt word 2 on readback.
    always @(posedge clock) begin
        if (imem_write_en) mem[imem_address] <= imem_dataIn;
        if (imem_read_en) imem_dataOut <= (corrupt && imem_address == 3'd2) ? 32'hFFFF_FFFF : mem[imem_address];
    end

    // Monitor: every memory write must match the next expected write.
    always @(negedge clock) begin
        if (imem_write_en) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_write: got addr %0h data %08h, required no write", imem_address, imem_dataIn);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (imem_address !== e.addr || imem_dataIn !== e.data) begin
                    errors++;
                    $display("[TB] FAIL write: got addr %0h data %08h, required addr %0h data %08h", imem_address, imem_dataIn, e.addr, e.data);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic startLoad();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    // Offer one word for one cycle; push it to the scoreboard if it should land.
    task automatic applyStimulus(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic last, input logic expect_write);
        wr_t e;
        if (expect_write) begin
            e.addr = addr;
            e.data = data;
            exp_q.push_back(e);
        end
        prog_valid = 1'b1;
        address_in = addr;
        program_in = data;
        prog_last  = last;
        tick();
        prog_valid = 1'b0;
        prog_last  = 1'b0;
    endtask

    // Count verify cycles until done or error, with a bounded budget.
    task automatic waitResult(output int n);
        n = 0;
        while (n < 100) begin
            @(negedge clock);
            if (load_done || load_error) break;
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("[TB] FAIL wait_result: got timeout, required done or error");
        end
    endtask

    initial begin
        logic [DW-1:0] img [0:3];
        img[0] = 32'h0000_0013;
        img[1] = 32'h0010_0093;
        img[2] = 32'h0020_0113;
        img[3] = 32'h0020_81B3;
        for (int i = 0; i < 2**AW; i++) mem[i] = '0;

        tick();
        tick();
        @(negedge clock);
        checkOutput("rst_core_reset", core_reset, 1);
        checkOutput("rst_prog_ready", prog_ready, 0);
        checkOutput("rst_load_done", load_done, 0);
        checkOutput("rst_load_error", load_error, 0);
        checkOutput("rst_words", words_loaded, 0);
        checkOutput("rst_we", imem_write_en, 0);
        checkOutput("rst_re", imem_read_en, 0);
        checkOutput("rst_addr", imem_address, 0);
        checkOutput("rst_din", imem_dataIn, 0);
        reset = 1'b0;
        tick();

        $display("[TB] 4-word load");
        startLoad();
        for (int i = 0; i < 4; i++) applyStimulus(AW'(i), img[i], i == 3, 1'b1);
        waitResult(cycles);
        checkOutput("verify_cycles_4", cycles, 5);
        checkOutput("done_4", load_done, 1);
        checkOutput("core_reset_run", core_reset, 0);
        checkOutput("words_4", words_loaded, 4);
        tick();
        core_imem_address = 3'd5;
        core_imem_read_en = 1'b1;
        @(negedge clock);
        checkOutput("run_addr_5", imem_address, 5);
        checkOutput("run_re_1", imem_read_en, 1);
        checkOutput("run_we_0", imem_write_en, 0);
        core_imem_address = 3'd2;
        core_imem_read_en = 1'b0;
        @(negedge clock);
        checkOutput("run_addr_2", imem_address, 2);
        checkOutput("run_re_0", imem_read_en, 0);
        tick();

        $display("[TB] reload from RUN");
        startLoad();
        @(negedge clock);
        checkOutput("reload_core_reset", core_reset, 1);
        checkOutput("reload_done", load_done, 0);
        checkOutput("reload_ready", prog_ready, 1);
        checkOutput("reload_words", words_loaded, 0);
        tick();

        $display("[TB] backpressure gaps");
        applyStimulus(3'd0, 32'h1111_1111, 1'b0, 1'b1);
        address_in = 3'd1;
        program_in = 32'hBAD0_BAD0;
        tick();
        tick();
        applyStimulus(3'd1, 32'h2222_2222, 1'b1, 1'b1);
        waitResult(cycles);
        checkOutput("verify_cycles_gap", cycles, 3);
        checkOutput("done_gap", load_done, 1);
        checkOutput("words_gap", words_loaded, 2);
        tick();

        $display("[TB] non-sequential address");
        startLoad();
        applyStimulus(3'd0, img[0], 1'b0, 1'b1);
        applyStimulus(3'd1, img[1], 1'b0, 1'b1);
        applyStimulus(3'd5, img[2], 1'b0, 1'b0);
        @(negedge clock);
        checkOutput("seq_error", load_error, 1);
        checkOutput("seq_core_reset", core_reset, 1);
        checkOutput("seq_done", load_done, 0);
        checkOutput("seq_words", words_loaded, 2);
        checkOutput("seq_ready", prog_ready, 0);
        tick();
        applyStimulus(3'd2, img[2], 1'b0, 1'b0);
        @(negedge clock);
        checkOutput("err_sticky", load_error, 1);
        tick();

        $display("[TB] corrupted readback");
        corrupt = 1'b1;
        startLoad();
        @(negedge clock);
        checkOutput("start_clears_error", load_error, 0);
        tick();
        for (int i = 0; i < 4; i++) applyStimulus(AW'(i), img[i], i == 3, 1'b1);
        waitResult(cycles);
        checkOutput("verify_cycles_bad", cycles, 5);
        checkOutput("bad_error", load_error, 1);
        checkOutput("bad_done", load_done, 0);
        corrupt = 1'b0;
        tick();

        $display("[TB] overflow");
        startLoad();
        for (int i = 0; i < 8; i++) applyStimulus(AW'(i), 32'h100 + i, 1'b0, 1'b1);
        applyStimulus(3'd0, 32'hCAFE_F00D, 1'b0, 1'b0);
        @(negedge clock);
        checkOutput("ovf_error", load_error, 1);
        checkOutput("ovf_words", words_loaded, 8);
        tick();

        $display("[TB] single-word image");
        startLoad();
        applyStimulus(3'd0, 32'hDEAD_BEEF, 1'b1, 1'b1);
        waitResult(cycles);
        checkOutput("verify_cycles_1", cycles, 2);
        checkOutput("done_1", load_done, 1);
        tick();

        $display("[TB] load_start with accept, then reset mid-verify");
        startLoad();
        load_start = 1'b1;
        applyStimulus(3'd0, 32'h5555_5555, 1'b0, 1'b0);
        load_start = 1'b0;
        @(negedge clock);
        checkOutput("drop_words", words_loaded, 0);
        checkOutput("drop_ready", prog_ready, 1);
        tick();
        for (int i = 0; i < 4; i++) applyStimulus(AW'(i), img[i], i == 3, 1'b1);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clock);
        checkOutput("mid_rst_core_reset", core_reset, 1);
        checkOutput("mid_rst_ready", prog_ready, 0);
        checkOutput("mid_rst_done", load_done, 0);
        checkOutput("mid_rst_error", load_error, 0);
        checkOutput("mid_rst_words", words_loaded, 0);
        checkOutput("mid_rst_re", imem_read_en, 0);
        checkOutput("mid_rst_addr", imem_address, 0);
        tick();
        checkOutput("wr_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
